// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths and the MDU result entry type for the register-file
// write-back arbiter (rf_wb_arbiter, wb_fifo, rf_wb_arbiter_if).
//   AW         register address width
//   DW         register data width
//   REG_ZERO   address of the hardwired-zero register
//   wb_entry_t one buffered MDU result {wa, wd}
package rf_wb_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } wb_entry_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: every signal between the pipeline, decode, the MDU and the
// register-file write port, bundled for rf_wb_arbiter.
//   pipe_we/pipe_wa/pipe_wd         in-order pipeline write-back
//   issue_valid/issue_wa            decode issuing an MDU op
//   mdu_valid/mdu_ready/mdu_wa/wd   MDU result handshake
//   we/wa/wd                        register-file write port
//   busy                            pending MDU destinations, one bit per register
//   stall_req                       request to freeze the pipeline so results drain
// Modports: master = environment side, slave = arbiter side.
interface rf_wb_arbiter_if;
  import rf_wb_pkg::*;

  logic            pipe_we;
  logic [AW-1:0]   pipe_wa;
  logic [DW-1:0]   pipe_wd;
  logic            issue_valid;
  logic [AW-1:0]   issue_wa;
  logic            mdu_valid;
  logic            mdu_ready;
  logic [AW-1:0]   mdu_wa;
  logic [DW-1:0]   mdu_wd;
  logic            we;
  logic [AW-1:0]   wa;
  logic [DW-1:0]   wd;
  logic [2**AW-1:0] busy;
  logic            stall_req;

  modport master (
    output pipe_we, pipe_wa, pipe_wd, issue_valid, issue_wa,
           mdu_valid, mdu_wa, mdu_wd,
    input  mdu_ready, we, wa, wd, busy, stall_req
  );

  modport slave (
    input  pipe_we, pipe_wa, pipe_wd, issue_valid, issue_wa,
           mdu_valid, mdu_wa, mdu_wd,
    output mdu_ready, we, wa, wd, busy, stall_req
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry FIFO of MDU results.
//   clk, rstn  clock, asynchronous active-low reset
//   push, din  write an entry (caller guarantees !full)
//   pop, dout  head entry, removed at the posedge when pop (caller guarantees !empty)
//   full, empty, count  occupancy from the registered count
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  wb_entry_t     din,
  input  logic          pop,
  output wb_entry_t     dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back arbiter in front of the register file's single
// write port. Pipeline write-back always wins; buffered MDU results use the
// port whenever the pipeline is not writing a real register.
//   clk, rstn  clock, asynchronous active-low reset
//   bus        rf_wb_arbiter_if.slave (pipeline, decode issue, MDU handshake,
//              RF write port, busy scoreboard, stall_req)
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rstn,
  rf_wb_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_entry_t        head;
  wb_entry_t        mdu_entry;
  logic             full;
  logic             empty;
  logic [CW-1:0]    fifo_count;
  logic             push;
  logic             pop;
  logic             pipe_grant;
  logic             blocked;
  logic [2**AW-1:0] busy_q;
  logic [2**AW-1:0] busy_d;
  logic [SW-1:0]    starve_cnt;
  logic             stall_q;

  assign mdu_entry = '{wa: bus.mdu_wa, wd: bus.mdu_wd};

  // A pipeline write to x0 is a no-op, so it does not take the port away.
  assign pipe_grant = bus.pipe_we && (bus.pipe_wa != REG_ZERO);
  assign pop        = !empty && !pipe_grant;
  assign blocked    = !empty && pipe_grant;
  // Ready comes from the registered count only; a same-cycle pop does not help.
  assign push       = bus.mdu_valid && !full;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (mdu_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    bus.we = bus.pipe_we;
    bus.wa = bus.pipe_wa;
    bus.wd = bus.pipe_wd;
    if (pop) begin
      // A result destined for x0 still pops, but never writes.
      bus.we = (head.wa != REG_ZERO);
      bus.wa = head.wa;
      bus.wd = head.wd;
    end
  end

  // Clear first, then set, so an issue to a register whose result is landing
  // in the same cycle keeps it marked busy.
  always_comb begin
    busy_d = busy_q;
    if (pop && (head.wa != REG_ZERO)) busy_d[head.wa] = 1'b0;
    if (bus.issue_valid && (bus.issue_wa != REG_ZERO)) busy_d[bus.issue_wa] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q     <= '0;
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (pop || empty)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
      stall_q <= ((starve_cnt == SW'(STARVE_MAX - 1)) && blocked) || (stall_q && !pop);
    end
  end

  assign bus.mdu_ready = !full;
  assign bus.busy      = busy_q;
  assign bus.stall_req = stall_q;

  a_mdu_hold: assert property (@(posedge clk) disable iff (!rstn)
    (bus.mdu_valid && !bus.mdu_ready) |=>
      (bus.mdu_valid && $stable(bus.mdu_wa) && $stable(bus.mdu_wd)))
    else $error("MDU result changed while waiting for mdu_ready");

  // The register being retired by this cycle's head write counts as free.
  a_issue_free: assert property (@(posedge clk) disable iff (!rstn)
    (bus.issue_valid && (bus.issue_wa != REG_ZERO)) |->
      (!busy_q[bus.issue_wa] || (pop && (head.wa == bus.issue_wa))))
    else $error("MDU op issued to a register with a pending write");

  a_count_range: assert property (@(posedge clk) disable iff (!rstn)
    fifo_count <= CW'(DEPTH))
    else $error("FIFO count out of range");

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rf_wb_arbiter_if bus();

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of pending results, a busy bit-set, a count of
  // consecutive blocked cycles and the stall flag.
  typedef struct {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } ent_t;

  ent_t             mq[$];
  logic [2**AW-1:0] m_busy;
  int               m_run;
  logic             m_stall;
  logic             m_pop;
  logic             m_accept;
  logic             exp_we;
  logic [AW-1:0]    exp_wa;
  logic [DW-1:0]    exp_wd;
  logic             exp_ready;

  task automatic clear_inputs();
    bus.pipe_we = 1'b0; bus.pipe_wa = '0; bus.pipe_wd = '0;
    bus.issue_valid = 1'b0; bus.issue_wa = '0;
    bus.mdu_valid = 1'b0; bus.mdu_wa = '0; bus.mdu_wd = '0;
  endtask

  task automatic model_eval();
    logic pg;
    pg        = bus.pipe_we && (bus.pipe_wa != 0);
    m_pop     = (mq.size() > 0) && !pg;
    exp_ready = (mq.size() < DEPTH);
    m_accept  = bus.mdu_valid && exp_ready;
    exp_we = bus.pipe_we; exp_wa = bus.pipe_wa; exp_wd = bus.pipe_wd;
    if (m_pop) begin
      exp_we = (mq[0].wa != 0); exp_wa = mq[0].wa; exp_wd = mq[0].wd;
    end
  endtask

  // Advance model and DUT by one clock; returns at posedge + 1.
  task automatic tick();
    logic blocked;
    ent_t e;
    model_eval();
    blocked = (mq.size() > 0) && !m_pop;
    if (m_pop && mq[0].wa != 0) m_busy[mq[0].wa] = 1'b0;
    if (bus.issue_valid && bus.issue_wa != 0) m_busy[bus.issue_wa] = 1'b1;
    m_run   = blocked ? m_run + 1 : 0;
    m_stall = (blocked && m_run == STARVE_MAX) || (m_stall && !m_pop);
    if (m_pop) void'(mq.pop_front());
    if (m_accept) begin
      e.wa = bus.mdu_wa; e.wd = bus.mdu_wd;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete(); m_busy = '0; m_run = 0; m_stall = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    model_reset();
    #1;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3; bus.pipe_wd = 32'h3333;
    for (int i = 0; i < 3; i++) begin
      bus.mdu_valid = 1'b1; bus.mdu_wa = 5'(i + 1); bus.mdu_wd = 32'h100 + i;
      bus.issue_valid = 1'b1; bus.issue_wa = 5'(i + 1);
      tick();
    end
    bus.mdu_valid = 1'b0; bus.issue_valid = 1'b0;
    checks++;
    if (dut.fifo_count !== 3'd3) begin
      failures++; $display("FAIL reset_precount: got %0d expected 3", dut.fifo_count);
    end
    #2 rstn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut.fifo_count !== 3'd0) begin
      failures++; $display("FAIL reset_count: got %0d expected 0", dut.fifo_count);
    end
    checks++;
    if (bus.busy !== 32'h0) begin
      failures++; $display("FAIL reset_busy: got %h expected 0", bus.busy);
    end
    checks++;
    if (bus.stall_req !== 1'b0) begin
      failures++; $display("FAIL reset_stall: got %b expected 0", bus.stall_req);
    end
    checks++;
    if (bus.mdu_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b expected 1", bus.mdu_ready);
    end
    checks++;
    if (bus.we !== 1'b1 || bus.wa !== 5'd3 || bus.wd !== 32'h3333) begin
      failures++;
      $display("FAIL reset_passthru: got we=%b wa=%0d wd=%h expected 1/3/3333", bus.we, bus.wa, bus.wd);
    end
    @(negedge clk) rstn = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
  endtask

  task automatic test_pipe_only();
    do_reset();
    bus.pipe_we = 1'b1; bus.pipe_wa = 5'd5; bus.pipe_wd = 32'hA5A5;
    @(negedge clk);
    checks++;
    if (bus.we !== 1'b1 || bus.wa !== 5'd5 || bus.wd !== 32'hA5A5) begin
      failures++;
      $display("FAIL pipe_only: got we=%b wa=%0d wd=%h expected 1/5/a5a5", bus.we, bus.wa, bus.wd);
    end
    tick();
    bus.pipe_we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.we !== 1'b0) begin
      failures++; $display("FAIL pipe_idle: got we=%b expected 0", bus.we);
    end
    tick();
  endtask

  task automatic test_drain();
    do_reset();
    bus.issue_valid = 1'b1; bus.issue_wa = 5'd7;
    tick();
    bus.issue_valid = 1'b0;
    checks++;
    if (bus.busy[7] !== 1'b1) begin
      failures++; $display("FAIL drain_busy_set: got %b expected 1", bus.busy[7]);
    end
    bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd7; bus.mdu_wd = 32'h1234;
    tick();
    bus.mdu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.we !== 1'b1 || bus.wa !== 5'd7 || bus.wd !== 32'h1234) begin
      failures++;
      $display("FAIL drain_write: got we=%b wa=%0d wd=%h expected 1/7/1234", bus.we, bus.wa, bus.wd);
    end
    checks++;
    if (bus.busy[7] !== 1'b1) begin
      failures++; $display("FAIL drain_busy_pending: got %b expected 1", bus.busy[7]);
    end
    tick();
    checks++;
    if (bus.busy[7] !== 1'b0) begin
      failures++; $display("FAIL drain_busy_clear: got %b expected 0", bus.busy[7]);
    end
  endtask

  task automatic test_fill();
    do_reset();
    bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3; bus.pipe_wd = 32'hCAFE;
    for (int i = 0; i < DEPTH; i++) begin
      bus.mdu_valid = 1'b1; bus.mdu_wa = 5'(16 + i); bus.mdu_wd = 32'hF000_0000 + i;
      @(negedge clk);
      checks++;
      if (bus.mdu_ready !== 1'b1) begin
        failures++; $display("FAIL fill_ready_%0d: got %b expected 1", i, bus.mdu_ready);
      end
      tick();
    end
    bus.mdu_wa = 5'd20; bus.mdu_wd = 32'hF000_0004;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mdu_ready !== 1'b0 || bus.we !== 1'b1 || bus.wa !== 5'd3) begin
        failures++;
        $display("FAIL fill_full_%0d: got ready=%b we=%b wa=%0d expected 0/1/3", i, bus.mdu_ready, bus.we, bus.wa);
      end
      tick();
    end
    bus.pipe_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.we !== 1'b1 || bus.wa !== 5'(16 + i) || bus.wd !== 32'hF000_0000 + i) begin
        failures++;
        $display("FAIL fill_order_%0d: got we=%b wa=%0d wd=%h expected 1/%0d/%h",
                 i, bus.we, bus.wa, bus.wd, 16 + i, 32'hF000_0000 + i);
      end
      if (i < 2) begin
        checks++;
        if (bus.mdu_ready !== (i == 1)) begin
          failures++; $display("FAIL fill_ready_drain_%0d: got %b expected %0d", i, bus.mdu_ready, i == 1);
        end
      end
      tick();
      if (i == 1) bus.mdu_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (dut.fifo_count !== 3'd0) begin
      failures++; $display("FAIL fill_empty: got %0d expected 0", dut.fifo_count);
    end
    tick();
  endtask

  task automatic test_starvation();
    do_reset();
    bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3; bus.pipe_wd = 32'h3;
    bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd20; bus.mdu_wd = 32'h5555;
    tick();
    bus.mdu_valid = 1'b0;
    for (int k = 0; k < STARVE_MAX; k++) begin
      @(negedge clk);
      checks++;
      if (bus.stall_req !== 1'b0) begin
        failures++; $display("FAIL starve_early_%0d: got %b expected 0", k, bus.stall_req);
      end
      tick();
    end
    checks++;
    if (bus.stall_req !== 1'b1) begin
      failures++; $display("FAIL starve_assert: got %b expected 1", bus.stall_req);
    end
    bus.pipe_we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.we !== 1'b1 || bus.wa !== 5'd20 || bus.stall_req !== 1'b1) begin
      failures++;
      $display("FAIL starve_pop: got we=%b wa=%0d stall=%b expected 1/20/1", bus.we, bus.wa, bus.stall_req);
    end
    tick();
    checks++;
    if (bus.stall_req !== 1'b0) begin
      failures++; $display("FAIL starve_release: got %b expected 0", bus.stall_req);
    end
  endtask

  task automatic test_corners();
    do_reset();
    bus.issue_valid = 1'b1; bus.issue_wa = 5'd4;
    tick();
    bus.issue_valid = 1'b0;
    bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3;
    bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd0; bus.mdu_wd = 32'hDEAD;
    tick();
    bus.mdu_valid = 1'b0; bus.pipe_we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.we !== 1'b0 || bus.busy !== 32'h10) begin
      failures++; $display("FAIL x0_head: got we=%b busy=%h expected 0/10", bus.we, bus.busy);
    end
    tick();
    checks++;
    if (dut.fifo_count !== 3'd0 || bus.busy !== 32'h10) begin
      failures++;
      $display("FAIL x0_popped: got count=%0d busy=%h expected 0/10", dut.fifo_count, bus.busy);
    end
    bus.issue_valid = 1'b1; bus.issue_wa = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3;
    bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd9; bus.mdu_wd = 32'h99;
    tick();
    bus.mdu_valid = 1'b0; bus.pipe_we = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_wa = 5'd9;
    @(negedge clk);
    checks++;
    if (bus.we !== 1'b1 || bus.wa !== 5'd9 || bus.wd !== 32'h99) begin
      failures++;
      $display("FAIL set_clear_write: got we=%b wa=%0d wd=%h expected 1/9/99", bus.we, bus.wa, bus.wd);
    end
    tick();
    bus.issue_valid = 1'b0;
    checks++;
    if (bus.busy !== 32'h210) begin
      failures++; $display("FAIL set_wins: got busy=%h expected 210", bus.busy);
    end
  endtask

  task automatic test_random();
    logic          hold;
    logic [AW-1:0] cand;
    int            pct;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      hold = bus.mdu_valid && !m_accept;
      if (!hold) begin
        bus.mdu_valid = ($urandom_range(0, 99) < 50);
        bus.mdu_wa    = 5'($urandom_range(0, 31));
        bus.mdu_wd    = $urandom;
      end
      pct = ((cyc / 100) % 2 == 0) ? 95 : 40;
      bus.pipe_we = !m_stall && ($urandom_range(0, 99) < pct);
      bus.pipe_wa = 5'($urandom_range(0, 31));
      bus.pipe_wd = $urandom;
      cand = 5'($urandom_range(0, 31));
      bus.issue_valid = ($urandom_range(0, 3) == 0) && !m_busy[cand];
      bus.issue_wa    = cand;
      @(negedge clk);
      model_eval();
      checks++;
      if (bus.we !== exp_we) begin
        failures++; $display("FAIL rand_we c%0d: got %b expected %b", cyc, bus.we, exp_we);
      end
      checks++;
      if (bus.wa !== exp_wa) begin
        failures++; $display("FAIL rand_wa c%0d: got %0d expected %0d", cyc, bus.wa, exp_wa);
      end
      checks++;
      if (bus.wd !== exp_wd) begin
        failures++; $display("FAIL rand_wd c%0d: got %h expected %h", cyc, bus.wd, exp_wd);
      end
      checks++;
      if (bus.mdu_ready !== exp_ready) begin
        failures++; $display("FAIL rand_ready c%0d: got %b expected %b", cyc, bus.mdu_ready, exp_ready);
      end
      checks++;
      if (bus.busy !== m_busy) begin
        failures++; $display("FAIL rand_busy c%0d: got %h expected %h", cyc, bus.busy, m_busy);
      end
      checks++;
      if (bus.stall_req !== m_stall) begin
        failures++; $display("FAIL rand_stall c%0d: got %b expected %b", cyc, bus.stall_req, m_stall);
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    rstn = 1'b0;
    test_reset();
    test_pipe_only();
    test_drain();
    test_fill();
    test_starvation();
    test_corners();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
